// File: rtl/cpu_writeback_pkg.sv
// Shared definitions for the write-back stage: opcodes, data-memory access types, FSM states,
// and instruction-class helpers.
package cpu_writeback_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LD     = 8'h01;
  localparam logic [7:0] OP_LDN    = 8'h02;
  localparam logic [7:0] OP_LDI    = 8'h03;
  localparam logic [7:0] OP_ST     = 8'h04;
  localparam logic [7:0] OP_STN    = 8'h05;
  localparam logic [7:0] OP_S      = 8'h06;
  localparam logic [7:0] OP_R      = 8'h07;
  localparam logic [7:0] OP_AND    = 8'h08;
  localparam logic [7:0] OP_ANDN   = 8'h09;
  localparam logic [7:0] OP_ANDI   = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_ORN    = 8'h0C;
  localparam logic [7:0] OP_ORI    = 8'h0D;
  localparam logic [7:0] OP_XOR    = 8'h0E;
  localparam logic [7:0] OP_XORN   = 8'h0F;
  localparam logic [7:0] OP_XORI   = 8'h10;
  localparam logic [7:0] OP_NOT    = 8'h11;
  localparam logic [7:0] OP_EQU    = 8'h12;
  localparam logic [7:0] OP_F_TRIG = 8'h13;
  localparam logic [7:0] OP_R_TRIG = 8'h14;

  typedef enum logic [1:0] {
    DM_BIT   = 2'b00,
    DM_BYTE  = 2'b01,
    DM_WORD  = 2'b10,
    DM_DWORD = 2'b11
  } dm_type_t;

  typedef enum logic [2:0] {
    WB_IDLE  = 3'd0,
    WB_READ  = 3'd1,
    WB_WAIT  = 3'd2,
    WB_WRITE = 3'd3,
    WB_DONE  = 3'd4
  } wb_state_t;

  function automatic logic is_cr_only(input logic [7:0] op);
    case (op)
      OP_LD, OP_LDN, OP_LDI, OP_AND, OP_ANDN, OP_ANDI, OP_OR, OP_ORN, OP_ORI,
      OP_XOR, OP_XORN, OP_XORI, OP_NOT, OP_EQU: is_cr_only = 1'b1;
      default:                                  is_cr_only = 1'b0;
    endcase
  endfunction

  function automatic logic is_both(input logic [7:0] op);
    is_both = (op == OP_F_TRIG) || (op == OP_R_TRIG);
  endfunction

  // S and R only store when the current result is true.
  function automatic logic is_cond(input logic [7:0] op);
    is_cond = (op == OP_S) || (op == OP_R);
  endfunction

  function automatic logic is_dm_write(input logic [7:0] op);
    is_dm_write = (op == OP_ST) || (op == OP_STN) || is_cond(op) || is_both(op);
  endfunction

endpackage

// File: rtl/cpu_writeback_merge.sv
// wb_merge: combinational merge of new ALU data into an old memory dword by access type.
// Unused select bits are ignored for BYTE and WORD accesses.
module wb_merge
  import cpu_writeback_pkg::*;
(
  input  logic [31:0] i_old,
  input  logic [31:0] i_new,
  input  dm_type_t    i_type,
  input  logic [4:0]  i_sel,
  output logic [31:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    case (i_type)
      DM_BIT:  o_merged[i_sel] = i_new[0];
      DM_BYTE: begin
        case (i_sel[1:0])
          2'd0:    o_merged[7:0]   = i_new[7:0];
          2'd1:    o_merged[15:8]  = i_new[7:0];
          2'd2:    o_merged[23:16] = i_new[7:0];
          default: o_merged[31:24] = i_new[7:0];
        endcase
      end
      DM_WORD: begin
        if (i_sel[0]) o_merged[31:16] = i_new[15:0];
        else          o_merged[15:0]  = i_new[15:0];
      end
      default: o_merged = i_new;
    endcase
  end

endmodule

// File: rtl/cpu_writeback.sv
// Write-back stage: owns CR, commits ALU data-memory results (sub-word via read-modify-write).
// Optional one-entry write cache enabled by defining WB_WRITE_CACHE_EN.
module cpu_writeback
  import cpu_writeback_pkg::*;
#(
  parameter int DM_ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_start,
  input  logic [7:0]           instr_code,
  input  logic [31:0]          alu_out_cr,
  input  logic [31:0]          alu_out_dm,
  input  logic [1:0]           dm_type,
  input  logic [DM_ADDR_W-1:0] dm_addr,
  input  logic [4:0]           dm_sel,
  input  logic [31:0]          dm_rd_data,
  output logic [31:0]          cr_out,
  output logic                 dm_rd_en,
  output logic                 dm_wr_en,
  output logic [DM_ADDR_W-1:0] dm_addr_out,
  output logic [31:0]          dm_wr_data,
  output logic                 wb_busy,
  output logic                 wb_done
);

  wb_state_t            r_state, w_state_nxt;
  logic [31:0]          r_cr, r_cr_new, r_new, r_old;
  dm_type_t             r_type;
  logic [4:0]           r_sel;
  logic [DM_ADDR_W-1:0] r_addr;
  logic                 r_upd_cr;
  logic                 w_go_write;
  logic                 w_hit;
  logic [31:0]          w_merged;

`ifdef WB_WRITE_CACHE_EN
  logic                 r_c_vld;
  logic [DM_ADDR_W-1:0] r_c_addr;
  logic [31:0]          r_c_dat;

  assign w_hit = r_c_vld && (r_c_addr == dm_addr);
`else
  assign w_hit = 1'b0;
`endif

  assign w_go_write = is_dm_write(instr_code) && (!is_cond(instr_code) || r_cr[0]);

  wb_merge u_merge (
    .i_old    (r_old),
    .i_new    (r_new),
    .i_type   (r_type),
    .i_sel    (r_sel),
    .o_merged (w_merged)
  );

  always_comb begin
    w_state_nxt = r_state;
    dm_rd_en    = 1'b0;
    dm_wr_en    = 1'b0;
    dm_addr_out = '0;
    dm_wr_data  = '0;
    wb_done     = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (wb_start) begin
          if (!w_go_write)
            w_state_nxt = WB_DONE;
          else if ((dm_type_t'(dm_type) == DM_DWORD) || w_hit)
            w_state_nxt = WB_WRITE;
          else
            w_state_nxt = WB_READ;
        end
      end
      WB_READ: begin
        dm_rd_en    = 1'b1;
        dm_addr_out = r_addr;
        w_state_nxt = WB_WAIT;
      end
      WB_WAIT: begin
        dm_addr_out = r_addr;
        w_state_nxt = WB_WRITE;
      end
      WB_WRITE: begin
        dm_wr_en    = 1'b1;
        dm_addr_out = r_addr;
        dm_wr_data  = w_merged;
        w_state_nxt = WB_DONE;
      end
      WB_DONE: begin
        wb_done     = 1'b1;
        w_state_nxt = WB_IDLE;
      end
      default: w_state_nxt = WB_IDLE;
    endcase
  end

  assign wb_busy = (r_state != WB_IDLE);
  assign cr_out  = r_cr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= WB_IDLE;
      r_cr     <= '0;
      r_cr_new <= '0;
      r_new    <= '0;
      r_old    <= '0;
      r_type   <= DM_BIT;
      r_sel    <= '0;
      r_addr   <= '0;
      r_upd_cr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        WB_IDLE: begin
          if (wb_start) begin
            r_type   <= dm_type_t'(dm_type);
            r_sel    <= dm_sel;
            r_addr   <= dm_addr;
            r_new    <= alu_out_dm;
            r_cr_new <= alu_out_cr;
            r_upd_cr <= is_both(instr_code);
            // CR-only results must be visible in the DONE cycle that follows directly.
            if (is_cr_only(instr_code)) r_cr <= alu_out_cr;
`ifdef WB_WRITE_CACHE_EN
            if (w_hit) r_old <= r_c_dat;
`endif
          end
        end
        WB_WAIT:  r_old <= dm_rd_data;
        WB_WRITE: if (r_upd_cr) r_cr <= r_cr_new;
        default: ;
      endcase
    end
  end

`ifdef WB_WRITE_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c_vld  <= 1'b0;
      r_c_addr <= '0;
      r_c_dat  <= '0;
    end else if (r_state == WB_WRITE) begin
      r_c_vld  <= 1'b1;
      r_c_addr <= r_addr;
      r_c_dat  <= w_merged;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: expected memory/CR events are queued at issue time and a monitor
// compares every strobe and completion the DUT presents, including its cycle offset from start.
module tb_cpu_writeback;
  import cpu_writeback_pkg::*;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_start;
  logic [7:0]    instr_code;
  logic [31:0]   alu_out_cr, alu_out_dm, dm_rd_data;
  logic [1:0]    dm_type;
  logic [AW-1:0] dm_addr;
  logic [4:0]    dm_sel;
  logic [31:0]   cr_out, dm_wr_data;
  logic          dm_rd_en, dm_wr_en, wb_busy, wb_done;
  logic [AW-1:0] dm_addr_out;

  always #5 clk = ~clk;

  cpu_writeback #(.DM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .wb_start(wb_start), .instr_code(instr_code),
    .alu_out_cr(alu_out_cr), .alu_out_dm(alu_out_dm), .dm_type(dm_type),
    .dm_addr(dm_addr), .dm_sel(dm_sel), .dm_rd_data(dm_rd_data),
    .cr_out(cr_out), .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en),
    .dm_addr_out(dm_addr_out), .dm_wr_data(dm_wr_data),
    .wb_busy(wb_busy), .wb_done(wb_done)
  );

  // kind: 0 = read strobe, 1 = write strobe, 2 = done pulse (dat = cr_out)
  typedef struct {
    int            kind;
    int            off;
    logic [AW-1:0] addr;
    logic [31:0]   dat;
  } ev_t;

  ev_t           exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            start_cyc = 0;
  logic [31:0]   mem[256];
  logic [31:0]   ref_mem[256];
  logic [31:0]   ref_cr;
  bit            ref_c_vld;
  logic [AW-1:0] ref_c_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int off, input logic [AW-1:0] addr,
                      input logic [31:0] dat);
    ev_t e;
    e.kind = kind; e.off = off; e.addr = addr; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [AW-1:0] addr, input logic [31:0] dat);
    ev_t e;
    int  off;
    off = cyc - start_cyc;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event kind=%0d off=%0d addr=%h dat=%h required=none",
               kind, off, addr, dat);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.off != off || e.addr !== addr || e.dat !== dat) begin
        failures++;
        $display("FAIL event actual kind=%0d off=%0d addr=%h dat=%h required kind=%0d off=%0d addr=%h dat=%h",
                 kind, off, addr, dat, e.kind, e.off, e.addr, e.dat);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus the memory the DUT talks to.
  initial forever begin
    @(negedge clk);
    if (dm_rd_en) begin
      check_ev(0, dm_addr_out, 32'h0);
      dm_rd_data = mem[dm_addr_out];
    end
    if (dm_wr_en) begin
      check_ev(1, dm_addr_out, dm_wr_data);
      mem[dm_addr_out] = dm_wr_data;
    end
    if (wb_done) check_ev(2, '0, cr_out);
  end

  function automatic logic [31:0] merge_ref(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [1:0] typ, input logic [4:0] sel);
    int          sh;
    logic [31:0] m;
    case (typ)
      2'b00: begin sh = int'(sel);         m = 32'h1    << sh; end
      2'b01: begin sh = 8 * (int'(sel) % 4);  m = 32'hFF   << sh; end
      2'b10: begin sh = 16 * (int'(sel) % 2); m = 32'hFFFF << sh; end
      default: return nw;
    endcase
    return (old & ~m) | ((nw << sh) & m);
  endfunction

  // Behavioural model: queue the events one instruction must produce.
  task automatic model(input logic [7:0] op, input logic [31:0] crv, input logic [31:0] dmv,
                       input logic [1:0] typ, input logic [4:0] sel, input logic [AW-1:0] addr);
    bit          cr_only, both, dmw, cond, hit;
    int          off;
    logic [31:0] nv;
    cr_only = op inside {OP_LD, OP_LDN, OP_LDI, OP_AND, OP_ANDN, OP_ANDI, OP_OR, OP_ORN,
                         OP_ORI, OP_XOR, OP_XORN, OP_XORI, OP_NOT, OP_EQU};
    both    = op inside {OP_F_TRIG, OP_R_TRIG};
    cond    = op inside {OP_S, OP_R};
    dmw     = both || cond || (op inside {OP_ST, OP_STN});
`ifdef WB_WRITE_CACHE_EN
    hit = ref_c_vld && (ref_c_addr == addr);
`else
    hit = 1'b0;
`endif
    if (cr_only) begin
      ref_cr = crv;
      push(2, 1, '0, ref_cr);
    end else if (dmw && !(cond && !ref_cr[0])) begin
      off = 1;
      if (typ != 2'b11 && !hit) begin
        push(0, 1, addr, 32'h0);
        off = 3;
      end
      nv = merge_ref(ref_mem[addr], dmv, typ, sel);
      ref_mem[addr] = nv;
      ref_c_vld = 1'b1;
      ref_c_addr = addr;
      push(1, off, addr, nv);
      if (both) ref_cr = crv;
      push(2, off + 1, '0, ref_cr);
    end else begin
      push(2, 1, '0, ref_cr);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (wb_busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wb_busy) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // Issue one instruction at a negedge, re-pulse a junk start while busy, wait for idle.
  task automatic issue(input logic [7:0] op, input logic [31:0] crv, input logic [31:0] dmv,
                       input logic [1:0] typ, input logic [4:0] sel, input logic [AW-1:0] addr);
    model(op, crv, dmv, typ, sel, addr);
    instr_code = op; alu_out_cr = crv; alu_out_dm = dmv;
    dm_type = typ; dm_sel = sel; dm_addr = addr;
    start_cyc = cyc;
    wb_start = 1'b1;
    @(negedge clk);
    instr_code = OP_ST; alu_out_cr = $urandom; alu_out_dm = $urandom;
    dm_type = 2'($urandom_range(0, 3)); dm_sel = 5'($urandom); dm_addr = AW'($urandom);
    wb_start = 1'b1;
    @(negedge clk);
    wb_start = 1'b0;
    wait_idle();
  endtask

  initial begin
    logic [7:0] ops[22];
    logic [7:0] op;
    rst = 1'b1; wb_start = 1'b0; instr_code = '0; alu_out_cr = '0; alu_out_dm = '0;
    dm_type = '0; dm_addr = '0; dm_sel = '0; dm_rd_data = '0;
    ref_cr = '0; ref_c_vld = 1'b0; ref_c_addr = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_cr_out", cr_out, 32'h0);
    chk("rst_busy", {31'h0, wb_busy}, 32'h0);
    chk("rst_done", {31'h0, wb_done}, 32'h0);
    chk("rst_rd_en", {31'h0, dm_rd_en}, 32'h0);
    chk("rst_wr_en", {31'h0, dm_wr_en}, 32'h0);
    chk("rst_addr_out", {24'h0, dm_addr_out}, 32'h0);
    chk("rst_wr_data", dm_wr_data, 32'h0);

    issue(OP_LDI, 32'h1234_5678, 32'h0, 2'b00, 5'd0, 8'd0);
    chk("ldi_cr_out", cr_out, 32'h1234_5678);

    // Abort: sub-word store, junk start while busy, reset during WAIT.
    push(0, 1, 8'd9, 32'h0);
    instr_code = OP_ST; alu_out_dm = 32'h0000_00CD; dm_type = 2'b01; dm_sel = 5'd1;
    dm_addr = 8'd9; start_cyc = cyc; wb_start = 1'b1;
    @(negedge clk);
    instr_code = OP_LDI; alu_out_cr = 32'hFFFF_FFFF;
    @(negedge clk);
    wb_start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_cr = '0; ref_c_vld = 1'b0;
    chk("abort_cr_out", cr_out, 32'h0);
    chk("abort_busy", {31'h0, wb_busy}, 32'h0);
    repeat (4) @(negedge clk);
    chk("abort_mem_untouched", mem[9], ref_mem[9]);

    mem[5] = 32'h1122_3344; ref_mem[5] = 32'h1122_3344;
    issue(OP_ST, 32'h0, 32'h0000_00AB, 2'b01, 5'd2, 8'd5);
    chk("st_byte_mem", mem[5], 32'h11AB_3344);

    mem[7] = 32'h0; ref_mem[7] = 32'h0;
    issue(OP_S, 32'h0, 32'h1, 2'b00, 5'd31, 8'd7);
    chk("s_suppressed_mem", mem[7], 32'h0);
    issue(OP_LDI, 32'h0000_0001, 32'h0, 2'b00, 5'd0, 8'd0);
    issue(OP_S, 32'h0, 32'h1, 2'b00, 5'd31, 8'd7);
    chk("s_bit_mem", mem[7], 32'h8000_0000);

    issue(OP_ST, 32'h0, 32'hDEAD_BEEF, 2'b11, 5'd0, 8'd20);
    chk("st_dword_mem", mem[20], 32'hDEAD_BEEF);

    issue(OP_ST, 32'h0, 32'h0000_0011, 2'b01, 5'd0, 8'd30);
    issue(OP_ST, 32'h0, 32'h0000_0022, 2'b01, 5'd1, 8'd30);
    chk("back_to_back_mem", mem[30] & 32'h0000_FFFF, 32'h0000_2211);

    ops = '{OP_NOP, OP_LD, OP_LDN, OP_LDI, OP_ST, OP_STN, OP_S, OP_R, OP_AND, OP_ANDN,
            OP_ANDI, OP_OR, OP_ORN, OP_ORI, OP_XOR, OP_XORN, OP_XORI, OP_NOT, OP_EQU,
            OP_F_TRIG, OP_R_TRIG, 8'hF0};
    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 21)];
      if (op == 8'hF0) op = 8'($urandom_range(8'h15, 8'hFF));
      issue(op, $urandom, $urandom, 2'($urandom_range(0, 3)), 5'($urandom),
            AW'($urandom_range(0, 7)));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'h0);
    for (int a = 0; a < 8; a++) chk("final_mem", mem[a], ref_mem[a]);
    chk("final_cr", cr_out, ref_cr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- Write-back stage directly downstream of the CPU ALU.
- Latches one ALU result per instruction, owns the Current Result (CR) register, and commits ALU data-memory results to a 32-bit-wide data memory.
- Sub-word stores (BIT/BYTE/WORD) use read-modify-write; DWORD stores write directly.
- Sequenced by the control unit via a start/done handshake; cr_out feeds back to the ALU.

Parameters:
- DM_ADDR_W, 8, data memory dword-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wb_start  in  1  one-cycle pulse; sample the inputs below
- instr_code  in  8  instruction code (shared opcode include)
- alu_out_cr  in  32  ALU result for CR
- alu_out_dm  in  32  ALU result for data memory
- dm_type  in  2  access type: BIT=00, BYTE=01, WORD=10, DWORD=11
- dm_addr  in  DM_ADDR_W  dword address
- dm_sel  in  5  bit index (BIT), byte lane [1:0] (BYTE), half [0] (WORD)
- dm_rd_data  in  32  memory read data, valid 1 cycle after dm_rd_en
- cr_out  out  32  Current Result register
- dm_rd_en  out  1  memory read strobe
- dm_wr_en  out  1  memory write strobe
- dm_addr_out  out  DM_ADDR_W  memory address for read/write
- dm_wr_data  out  32  merged write data
- wb_busy  out  1  high while not IDLE
- wb_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0, cr_out=0, FSM in IDLE. Reset mid-operation aborts with no write issued.
- Capture: wb_start in IDLE latches every input. wb_start while busy is ignored.
- Instruction classes:
  - CR-only (LD, LDN, LDI, AND*, OR*, XOR*, NOT, EQU): cr_out<=alu_out_cr on the cycle after start; wb_done in that same cycle. Latency 1.
  - DM-only (ST, STN, S, R): CR unchanged.
  - Both (F_TRIG, R_TRIG): cr_out updated at the DONE cycle.
  - S/R are conditional: a write occurs only if cr_out[0]==1 at capture. Otherwise go straight to DONE, no dm_wr_en.
  - Any other opcode: no state change, wb_done after 1 cycle.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
  - IDLE->READ for sub-word DM writes.
  - IDLE->WRITE for DWORD.
  - IDLE->DONE for CR-only, suppressed S/R, or unknown opcode.
  - READ asserts dm_rd_en 1 cycle -> WAIT.
  - WAIT captures dm_rd_data -> WRITE.
  - WRITE asserts dm_wr_en 1 cycle -> DONE.
  - DONE pulses wb_done -> IDLE.
  - Latency start->done: sub-word 4 cycles, DWORD 2 cycles.
- Merge rules:
  - BIT: replace bit dm_sel with alu_out_dm[0].
  - BYTE: replace lane dm_sel[1:0] with alu_out_dm[7:0].
  - WORD: replace half dm_sel[0] with alu_out_dm[15:0].
  - DWORD: full alu_out_dm.
  - Unused dm_sel bits are ignored.
- dm_addr_out holds the captured address from READ through WRITE; 0 otherwise.

Optional Feature:
- Macro: WB_WRITE_CACHE_EN.
- Defined: a one-entry cache (valid, addr, data) records the last dword written.
  - A sub-word write whose address hits a valid entry skips READ/WAIT and merges into the cached data (latency 2).
  - Every write updates the cache; rst invalidates it.
- Undefined: sub-word writes always read memory first.

Decomposition:
- Shared package/include holds:
  - opcode constants (existing program include);
  - dm_type encodings BIT/BYTE/WORD/DWORD;
  - the FSM state encoding.
- Sub-module wb_merge: combinational (old dword, new data, dm_type, dm_sel) -> merged dword.

Test Plan:
- LDI with alu_out_cr=32'h1234_5678 -> cr_out=32'h1234_5678 one cycle after start, wb_done same cycle, no memory strobes.
- ST BYTE, addr 5, sel 2, alu_out_dm=32'h0000_00AB, memory holds 32'h1122_3344 -> dm_rd_en at cycle 1, dm_wr_data=32'h11AB_3344 with dm_wr_en at cycle 3, wb_done at cycle 4.
- S BIT, sel 31, cr_out[0]=0 -> no dm_wr_en, wb_done at cycle 1.
- S BIT, sel 31, cr_out[0]=1, memory 0 -> write 32'h8000_0000.
- ST DWORD, alu_out_dm=32'hDEAD_BEEF -> no read, write at cycle 1, done at cycle 2.
- wb_start re-pulsed while busy, and rst asserted in WAIT -> second start ignored; after reset no write, cr_out=0, wb_busy=0.
- With WB_WRITE_CACHE_EN: two back-to-back BYTE stores to the same address -> second store issues no dm_rd_en and completes in 2 cycles.
